// File: rtl/cc_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cc_pkg
// Description : Shared widths and loader state type for the Code Calculator
//               operand loader.
// Revision    : 1.0 - initial release
// ============================================================================
package cc_pkg;

    localparam int NIBBLE_W = 4;
    localparam int OPT_W    = 3;
    localparam int RES_W    = 9;
    localparam int NUM_OPND = 4;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        EVAL = 2'd1,
        HOLD = 2'd2
    } cc_ld_state_t;

endpackage
`default_nettype wire

// File: rtl/cc_gap_timer.sv
`default_nettype none
// ============================================================================
// Module      : cc_gap_timer
// Description : Counts idle cycles inside a partial frame and flags expiry
//               on the cycle the count would reach TIMEOUT_CYC.
//               Built only when CC_LOADER_TIMEOUT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`ifdef CC_LOADER_TIMEOUT_EN
module cc_gap_timer #(
    parameter int unsigned TIMEOUT_CYC = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic inc,
    output logic expire
);

    localparam int unsigned        c_cnt_w = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(TIMEOUT_CYC - 1);

    logic [c_cnt_w-1:0] r_cnt;

    // Expiry fires on the increment that would complete the gap, so the
    // counter never has to hold TIMEOUT_CYC itself.
    assign expire = inc && (r_cnt == c_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr || expire) begin
            r_cnt <= '0;
        end else if (inc) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule
`endif
`default_nettype wire

// File: rtl/cc_operand_loader.sv
`default_nettype none
// ============================================================================
// Module      : cc_operand_loader
// Description : Assembles four operand nibbles plus opcode for the CC core,
//               captures its result and holds it under valid/ready.
//               Optional partial-frame timeout: CC_LOADER_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module cc_operand_loader
    import cc_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [NIBBLE_W-1:0] in_data,
    input  logic [OPT_W-1:0]    in_opt,
    output logic                in_ready,
    output logic [NIBBLE_W-1:0] in_n0,
    output logic [NIBBLE_W-1:0] in_n1,
    output logic [NIBBLE_W-1:0] in_n2,
    output logic [NIBBLE_W-1:0] in_n3,
    output logic [OPT_W-1:0]    opt,
    input  logic [RES_W-1:0]    out_n,
    output logic                res_valid,
    output logic [RES_W-1:0]    res_data,
    input  logic                res_ready,
    output logic                busy,
    output logic                frame_err
);

    cc_ld_state_t        r_state;
    logic [1:0]          r_cnt;
    logic [NIBBLE_W-1:0] r_opnd [NUM_OPND];
    logic [OPT_W-1:0]    r_opt;
    logic [RES_W-1:0]    r_res;
    logic                w_accept;
    logic                w_expire;

    assign w_accept = in_valid && (r_state == LOAD);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= LOAD;
            r_cnt   <= '0;
            r_opt   <= '0;
            r_res   <= '0;
            for (int i = 0; i < NUM_OPND; i++) begin
                r_opnd[i] <= '0;
            end
        end else begin
            case (r_state)
                LOAD: begin
                    if (w_accept) begin
                        r_opnd[r_cnt] <= in_data;
                        if (r_cnt == 2'd0) begin
                            r_opt <= in_opt;
                        end
                        // 2-bit count wraps to 0 on the fourth nibble
                        r_cnt <= r_cnt + 2'd1;
                        if (r_cnt == 2'd3) begin
                            r_state <= EVAL;
                        end
                    end else if (w_expire) begin
                        r_cnt <= '0;
                        r_opt <= '0;
                        for (int i = 0; i < NUM_OPND; i++) begin
                            r_opnd[i] <= '0;
                        end
                    end
                end
                EVAL: begin
                    r_res   <= out_n;
                    r_state <= HOLD;
                end
                HOLD: begin
                    if (res_ready) begin
                        r_state <= LOAD;
                    end
                end
                default: begin
                    r_state <= LOAD;
                end
            endcase
        end
    end

`ifdef CC_LOADER_TIMEOUT_EN
    logic w_in_partial;
    logic w_gap_inc;
    logic w_gap_clr;
    logic r_frame_err;

    assign w_in_partial = (r_state == LOAD) && (r_cnt != 2'd0);
    assign w_gap_inc    = w_in_partial && !in_valid;
    assign w_gap_clr    = !w_in_partial || w_accept;

    cc_gap_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_gap_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (w_gap_clr),
        .inc    (w_gap_inc),
        .expire (w_expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_expire;
        end
    end

    assign frame_err = r_frame_err;
`else
    logic w_unused_timeout;

    assign w_expire         = 1'b0;
    assign frame_err        = 1'b0;
    assign w_unused_timeout = ^TIMEOUT_CYC;
`endif

    // Handshake outputs come from registered state only.
    assign in_ready  = (r_state == LOAD);
    assign res_valid = (r_state == HOLD);
    assign busy      = (r_state != LOAD) || (r_cnt != 2'd0);

    assign in_n0    = r_opnd[0];
    assign in_n1    = r_opnd[1];
    assign in_n2    = r_opnd[2];
    assign in_n3    = r_opnd[3];
    assign opt      = r_opt;
    assign res_data = r_res;

endmodule
`default_nettype wire

// File: tb/tb_cc_operand_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_cc_operand_loader
// Description : Self-checking bench for cc_operand_loader with a behavioural
//               frame model; honours CC_LOADER_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cc_operand_loader;
    import cc_pkg::*;

    localparam int unsigned c_timeout = 15;
`ifdef CC_LOADER_TIMEOUT_EN
    localparam bit c_has_timeout = 1'b1;
`else
    localparam bit c_has_timeout = 1'b0;
`endif
    localparam int c_collect = 0;
    localparam int c_eval    = 1;
    localparam int c_present = 2;

    logic                clk = 1'b0;
    logic                rst;
    logic                in_valid;
    logic [NIBBLE_W-1:0] in_data;
    logic [OPT_W-1:0]    in_opt;
    logic                in_ready;
    logic [NIBBLE_W-1:0] in_n0, in_n1, in_n2, in_n3;
    logic [OPT_W-1:0]    opt;
    logic [RES_W-1:0]    out_n;
    logic                res_valid;
    logic [RES_W-1:0]    res_data;
    logic                res_ready;
    logic                busy;
    logic                frame_err;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Behavioural frame model
    logic [NIBBLE_W-1:0] m_nib [4];
    logic [OPT_W-1:0]    m_opt;
    logic [RES_W-1:0]    m_res;
    int                  m_cnt;
    int                  m_stage;
    int unsigned         m_gap;
    logic                m_fe;

    cc_operand_loader #(
        .TIMEOUT_CYC (c_timeout)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_opt    (in_opt),
        .in_ready  (in_ready),
        .in_n0     (in_n0),
        .in_n1     (in_n1),
        .in_n2     (in_n2),
        .in_n3     (in_n3),
        .opt       (opt),
        .out_n     (out_n),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_ready (res_ready),
        .busy      (busy),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: actual=%0h required=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_nib[i] = '0;
        m_opt   = '0;
        m_res   = '0;
        m_cnt   = 0;
        m_stage = c_collect;
        m_gap   = 0;
        m_fe    = 1'b0;
    endtask

    task automatic model_step(input logic v, input logic [3:0] d, input logic [2:0] o,
                              input logic [8:0] on, input logic rr);
        m_fe = 1'b0;
        if (m_stage == c_collect) begin
            if (v) begin
                if (m_cnt == 0) m_opt = o;
                m_nib[m_cnt] = d;
                m_cnt++;
                m_gap = 0;
                if (m_cnt == 4) begin
                    m_cnt   = 0;
                    m_stage = c_eval;
                end
            end else if (m_cnt > 0 && c_has_timeout) begin
                m_gap++;
                if (m_gap == c_timeout) begin
                    m_gap = 0;
                    m_cnt = 0;
                    for (int i = 0; i < 4; i++) m_nib[i] = '0;
                    m_opt = '0;
                    m_fe  = 1'b1;
                end
            end
        end else if (m_stage == c_eval) begin
            m_res   = on;
            m_stage = c_present;
        end else if (rr) begin
            m_stage = c_collect;
        end
    endtask

    // Advance one edge; inputs are captured as the DUT sees them at the edge.
    task automatic tick();
        logic       s_rst = rst;
        logic       s_v   = in_valid;
        logic [3:0] s_d   = in_data;
        logic [2:0] s_o   = in_opt;
        logic [8:0] s_on  = out_n;
        logic       s_rr  = res_ready;
        @(posedge clk);
        #1;
        cyc++;
        if (s_rst) model_reset();
        else       model_step(s_v, s_d, s_o, s_on, s_rr);
    endtask

    always @(negedge clk) begin
        chk("in_ready",  16'(in_ready),  16'(m_stage == c_collect));
        chk("res_valid", 16'(res_valid), 16'(m_stage == c_present));
        chk("busy",      16'(busy),      16'((m_stage != c_collect) || (m_cnt != 0)));
        chk("in_n0",     16'(in_n0),     16'(m_nib[0]));
        chk("in_n1",     16'(in_n1),     16'(m_nib[1]));
        chk("in_n2",     16'(in_n2),     16'(m_nib[2]));
        chk("in_n3",     16'(in_n3),     16'(m_nib[3]));
        chk("opt",       16'(opt),       16'(m_opt));
        chk("res_data",  16'(res_data),  16'(m_res));
        chk("frame_err", 16'(frame_err), 16'(m_fe));
    end

    task automatic send_nib(input logic [3:0] d, input logic [2:0] o);
        in_valid = 1'b1;
        in_data  = d;
        in_opt   = o;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic wait_ready();
        int k = 0;
        while (!in_ready && k < 20) begin
            tick();
            k++;
        end
        if (!in_ready) chk("wait_ready", 16'(in_ready), 16'd1);
    endtask

    task automatic send_frame(input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                              input logic [3:0] d, input logic [2:0] o);
        wait_ready();
        send_nib(a, o);
        send_nib(b, 3'(o + 3'd1));
        send_nib(c, 3'(o + 3'd2));
        send_nib(d, 3'(o + 3'd3));
    endtask

    task automatic do_reset_async();
        rst = 1'b1;
        model_reset();
        #1;
        chk("rst_in_n0",     16'(in_n0),     16'd0);
        chk("rst_in_n1",     16'(in_n1),     16'd0);
        chk("rst_opt",       16'(opt),       16'd0);
        chk("rst_res_data",  16'(res_data),  16'd0);
        chk("rst_in_ready",  16'(in_ready),  16'd1);
        chk("rst_res_valid", 16'(res_valid), 16'd0);
        chk("rst_busy",      16'(busy),      16'd0);
        chk("rst_frame_err", 16'(frame_err), 16'd0);
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [8:0] vals [3];
        logic [2:0] first_opt;
        int         t_prev;
        int         k;
        int         pct;

        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_opt    = '0;
        out_n     = '0;
        res_ready = 1'b1;
        model_reset();
        tick();
        tick();
        rst = 1'b0;
        chk("init_in_ready", 16'(in_ready), 16'd1);
        chk("init_busy",     16'(busy),     16'd0);

        // Reset mid-frame after two accepts
        send_nib(4'h6, 3'd1);
        send_nib(4'h9, 3'd0);
        chk("mid_in_n1", 16'(in_n1), 16'd9);
        chk("mid_busy",  16'(busy),  16'd1);
        do_reset_async();
        send_nib(4'hA, 3'd4);
        chk("post_rst_in_n0", 16'(in_n0), 16'hA);
        chk("post_rst_in_n1", 16'(in_n1), 16'd0);
        chk("post_rst_opt",   16'(opt),   16'd4);
        send_nib(4'h1, 3'd0);
        send_nib(4'h2, 3'd0);
        send_nib(4'h3, 3'd0);
        tick();
        tick();

        // Basic frame
        res_ready = 1'b1;
        out_n     = 9'h1A5;
        wait_ready();
        send_nib(4'd3, 3'b010);
        send_nib(4'd5, 3'b111);
        send_nib(4'd7, 3'b001);
        send_nib(4'd9, 3'b100);
        chk("basic_in_n0",    16'(in_n0),     16'd3);
        chk("basic_in_n1",    16'(in_n1),     16'd5);
        chk("basic_in_n2",    16'(in_n2),     16'd7);
        chk("basic_in_n3",    16'(in_n3),     16'd9);
        chk("basic_opt",      16'(opt),       16'd2);
        chk("basic_eval_rdy", 16'(in_ready),  16'd0);
        tick();
        chk("basic_res_data",  16'(res_data),  16'h1A5);
        chk("basic_res_valid", 16'(res_valid), 16'd1);
        tick();
        chk("basic_ready_back", 16'(in_ready),  16'd1);
        chk("basic_res_drop",   16'(res_valid), 16'd0);

        // Backpressure with nibbles offered during HOLD
        res_ready = 1'b0;
        out_n     = 9'h0C3;
        send_frame(4'd1, 4'd2, 4'd4, 4'd8, 3'b101);
        tick();
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_data  = 4'($urandom);
            out_n    = 9'($urandom);
            tick();
            chk("bp_res_valid", 16'(res_valid), 16'd1);
            chk("bp_in_ready",  16'(in_ready),  16'd0);
            chk("bp_res_data",  16'(res_data),  16'h0C3);
            chk("bp_in_n0",     16'(in_n0),     16'd1);
            chk("bp_in_n3",     16'(in_n3),     16'd8);
        end
        in_valid  = 1'b0;
        res_ready = 1'b1;
        tick();
        chk("bp_release", 16'(in_ready), 16'd1);

        // Opcode sampling with bubbles
        wait_ready();
        first_opt = '0;
        k = 0;
        for (int i = 0; i < 40 && k < 4; i++) begin
            in_valid = (i % 2 == 0);
            in_data  = 4'(k + 6);
            in_opt   = 3'($urandom);
            if (i == 0) first_opt = in_opt;
            tick();
            if (i % 2 == 0) k++;
        end
        in_valid = 1'b0;
        chk("bub_opt",   16'(opt),   16'(first_opt));
        chk("bub_in_n0", 16'(in_n0), 16'd6);
        chk("bub_in_n3", 16'(in_n3), 16'd9);
        chk("bub_done",  16'(in_ready), 16'd0);
        tick();
        tick();

        // Partial frame followed by a long idle gap
        wait_ready();
        send_nib(4'hC, 3'd6);
        send_nib(4'h3, 3'd0);
`ifdef CC_LOADER_TIMEOUT_EN
        idle(14);
        chk("to_early_fe",   16'(frame_err), 16'd0);
        chk("to_early_n0",   16'(in_n0),     16'hC);
        idle(1);
        chk("to_fe",   16'(frame_err), 16'd1);
        chk("to_n0",   16'(in_n0),     16'd0);
        chk("to_n1",   16'(in_n1),     16'd0);
        chk("to_opt",  16'(opt),       16'd0);
        chk("to_busy", 16'(busy),      16'd0);
        idle(1);
        chk("to_fe_pulse", 16'(frame_err), 16'd0);
        out_n = 9'h0F0;
        send_frame(4'h4, 4'h5, 4'h6, 4'h7, 3'd3);
        chk("to_new_n0", 16'(in_n0), 16'h4);
        chk("to_new_n3", 16'(in_n3), 16'h7);
        tick();
        chk("to_new_res", 16'(res_data), 16'h0F0);
        tick();
`else
        idle(20);
        chk("nto_fe",   16'(frame_err), 16'd0);
        chk("nto_busy", 16'(busy),      16'd1);
        chk("nto_n0",   16'(in_n0),     16'hC);
        send_nib(4'h5, 3'd0);
        send_nib(4'h6, 3'd0);
        chk("nto_opt", 16'(opt), 16'd6);
        tick();
        tick();
`endif

        // Back-to-back frames
        res_ready = 1'b1;
        t_prev    = -1;
        for (int f = 0; f < 3; f++) begin
            vals[f] = 9'($urandom);
            wait_ready();
            for (int n = 0; n < 4; n++) send_nib(4'($urandom), 3'($urandom));
            out_n = vals[f];
            tick();
            chk("b2b_res_valid", 16'(res_valid), 16'd1);
            chk("b2b_res_data",  16'(res_data),  16'(vals[f]));
            if (f > 0) chk("b2b_period", 16'(cyc - t_prev), 16'd6);
            t_prev = cyc;
            tick();
        end

        // Randomized traffic, including long gaps and a mid-run reset
        pct = 90;
        for (int i = 0; i < 600; i++) begin
            if (i % 60 == 0) begin
                case ($urandom_range(0, 2))
                    0:       pct = 90;
                    1:       pct = 50;
                    default: pct = 3;
                endcase
            end
            in_valid  = ($urandom_range(0, 99) < pct);
            in_data   = 4'($urandom);
            in_opt    = 3'($urandom);
            out_n     = 9'($urandom);
            res_ready = ($urandom_range(0, 2) != 0);
            if (i == 300) do_reset_async();
            else          tick();
        end
        in_valid = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
